prog_loader: RTL

Loads a program image from a byte stream (UART receiver output) into the instruction memory read by the fetch stage. While loading, it holds the CPU in reset. It sits upstream of the instruction fetch unit and shares the instruction RAM write port. Bytes are packed big-endian into 32-bit words written at consecutive word addresses from 0. The load ends after an idle timeout.

---
 rtl/prog_loader_pkg.sv | 31 +++
 rtl/prog_loader_packer.sv | 42 ++++
 rtl/prog_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, word geometry
// and the byte-insert helper used by the packer.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      RECV  = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int BYTES_PER_WORD         = 4;
   localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

   // Big-endian placement: byte 0 of a word lands in the top byte lane.
   function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  data);
      logic [31:0] res;
      res = word;
      case (idx)
         2'd0:    res[31:24] = data;
         2'd1:    res[23:16] = data;
         2'd2:    res[15:8]  = data;
         default: res[7:0]   = data;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/prog_loader_packer.sv
// byte_word_packer: collects bytes big-endian into a 32-bit word. Unfilled low
// lanes stay zero so a partial word can be written out as-is.
module byte_word_packer
   import prog_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clr,
   input  logic        i_valid,
   input  logic [7:0]  i_data,
   output logic [31:0] o_word,
   output logic        o_word_ready,
   output logic        o_pending
);

   logic [1:0]  r_idx;
   logic [31:0] r_word;
   logic [31:0] w_ins;

   assign w_ins        = insert_byte(r_word, r_idx, i_data);
   assign o_word       = i_valid ? w_ins : r_word;
   assign o_word_ready = i_valid && (r_idx == 2'(BYTES_PER_WORD - 1));
   assign o_pending    = (r_idx != 2'd0);

   // Byte index and partial-word register; a completed word restarts from zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx  <= 2'd0;
         r_word <= 32'd0;
      end else if (i_clr) begin
         r_idx  <= 2'd0;
         r_word <= 32'd0;
      end else if (o_word_ready) begin
         r_idx  <= 2'd0;
         r_word <= 32'd0;
      end else if (i_valid) begin
         r_idx  <= r_idx + 2'd1;
         r_word <= w_ins;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams received bytes into instruction RAM as big-endian words,
// holding the CPU in reset until an idle timeout ends the load.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_WIDTH     = 14,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic                  i_byte_valid,
   input  logic [7:0]            i_byte_data,
   output logic                  o_imem_we,
   output logic [ADDR_WIDTH-1:0] o_imem_addr,
   output logic [31:0]           o_imem_wdata,
   output logic                  o_cpu_hold,
   output logic                  o_load_done,
   output logic [ADDR_WIDTH:0]   o_word_count,
   output logic                  o_err_overflow
);

   localparam int                  CW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]       IDLE_MAX = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_WIDTH:0] CAP      = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] CAP_M1   = {1'b0, {ADDR_WIDTH{1'b1}}};

   state_t                r_state, w_next_state;
   logic [CW-1:0]         r_idle_cnt;
   logic                  r_imem_we, r_cpu_hold, r_load_done, r_err_overflow;
   logic [ADDR_WIDTH-1:0] r_imem_addr;
   logic [31:0]           r_imem_wdata;
   logic [ADDR_WIDTH:0]   r_word_count;
   logic                  w_rx, w_full, w_accept, w_drop, w_timeout, w_clr;
   logic                  w_we_nxt, w_hold_nxt, w_done_nxt;
   logic [31:0]           w_word;
   logic                  w_word_ready, w_pending;

   assign w_rx      = (r_state == WAIT) || (r_state == RECV);
   // A strobe in flight has not reached word_count yet, so count it as written.
   assign w_full    = (r_word_count == CAP) || ((r_word_count == CAP_M1) && r_imem_we);
   assign w_accept  = i_byte_valid && w_rx && !w_full;
   assign w_drop    = i_byte_valid && w_rx && w_full;
   assign w_timeout = (r_state == RECV) && !i_byte_valid && (r_idle_cnt == IDLE_MAX);
   assign w_clr     = (r_state == IDLE) && i_start;

   byte_word_packer u_packer (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clr        (w_clr),
      .i_valid      (w_accept),
      .i_data       (i_byte_data),
      .o_word       (w_word),
      .o_word_ready (w_word_ready),
      .o_pending    (w_pending)
   );

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next_state;
   end

   // FSM next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (i_start) w_next_state = WAIT; else w_next_state = IDLE;
         WAIT:    if (i_byte_valid) w_next_state = RECV; else w_next_state = WAIT;
         RECV:    if (w_timeout) w_next_state = w_pending ? FLUSH : DONE;
                  else w_next_state = RECV;
         FLUSH:   w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // FSM output decode, registered below.
   always_comb begin
      w_we_nxt   = w_word_ready || (w_timeout && w_pending);
      w_hold_nxt = (w_next_state == WAIT) || (w_next_state == RECV) || (w_next_state == FLUSH);
      w_done_nxt = (w_next_state == DONE);
   end

   // Idle counter: any byte (accepted or dropped) restarts the timeout.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                              r_idle_cnt <= '0;
      else if ((r_state != RECV) || i_byte_valid) r_idle_cnt <= '0;
      else if (r_idle_cnt != IDLE_MAX)           r_idle_cnt <= r_idle_cnt + CW'(1);
   end

   // Registered outputs, write port and load bookkeeping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_imem_we      <= 1'b0;
         r_imem_addr    <= '0;
         r_imem_wdata   <= 32'd0;
         r_cpu_hold     <= 1'b0;
         r_load_done    <= 1'b0;
         r_word_count   <= '0;
         r_err_overflow <= 1'b0;
      end else begin
         r_imem_we   <= w_we_nxt;
         r_cpu_hold  <= w_hold_nxt;
         r_load_done <= w_done_nxt;
         if (w_we_nxt) begin
            r_imem_addr  <= r_word_count[ADDR_WIDTH-1:0];
            r_imem_wdata <= w_word;
         end
         if (w_clr) begin
            r_word_count   <= '0;
            r_err_overflow <= 1'b0;
         end else begin
            if (r_imem_we) r_word_count <= r_word_count + (ADDR_WIDTH+1)'(1);
            if (w_drop)    r_err_overflow <= 1'b1;
         end
      end
   end

   assign o_imem_we      = r_imem_we;
   assign o_imem_addr    = r_imem_addr;
   assign o_imem_wdata   = r_imem_wdata;
   assign o_cpu_hold     = r_cpu_hold;
   assign o_load_done    = r_load_done;
   assign o_word_count   = r_word_count;
   assign o_err_overflow = r_err_overflow;

endmodule
